// File: rtl/instruction_mem.sv
// Multi-port instruction store: one streaming program-load port, NUM_SM registered
// read ports, and a hardware zero-sweep after reset or on request.

module instruction_mem_rd_port #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              zero,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data,
  output logic              valid
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      // The store is only partly swept while clearing, so mask it entirely.
      if (en) data <= zero ? '0 : word;
    end
  end
endmodule

module instruction_mem_mp #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 32,
  parameter  int NUM_SM = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_req,
  output logic                     clear_busy,
  input  logic                     load_start,
  input  logic [AW-1:0]            load_base,
  input  logic [AW:0]              load_len,
  input  logic                     load_valid,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     load_ready,
  output logic                     load_done,
  input  logic [NUM_SM-1:0]        rd_en,
  input  logic [NUM_SM*AW-1:0]     rd_addr,
  output logic [NUM_SM*DATA_W-1:0] rd_data,
  output logic [NUM_SM-1:0]        rd_valid
);
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     ptr, ptr_nxt;
  logic [AW:0]       cnt, cnt_nxt;
  logic              done_nxt;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_CLEAR;
      ptr       <= '0;
      cnt       <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      load_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    we        = 1'b0;
    wdata     = '0;
    case (state)
      S_CLEAR: begin
        we      = 1'b1;
        ptr_nxt = ptr + AW'(1);
        if (ptr == AW'(DEPTH-1)) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        // Clear wins over a simultaneous load_start, which is dropped.
        if (clear_req) begin
          state_nxt = S_CLEAR;
          ptr_nxt   = '0;
        end else if (load_start) begin
          if (load_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = S_LOAD;
            ptr_nxt   = load_base;
            cnt_nxt   = load_len;
          end
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          we      = 1'b1;
          wdata   = load_data;
          ptr_nxt = ptr + AW'(1);
          cnt_nxt = cnt - (AW+1)'(1);
          if (cnt == (AW+1)'(1)) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Read ports sample the pre-write contents, giving read-before-write on collision.
  always_ff @(posedge clk) begin
    if (we) mem[ptr] <= wdata;
  end

  assign load_ready = (state == S_LOAD);
  assign clear_busy = (state == S_CLEAR);

  for (genvar i = 0; i < NUM_SM; i++) begin : g_port
    instruction_mem_rd_port #(.DATA_W(DATA_W)) u_port (
      .clk   (clk),
      .rst   (rst),
      .en    (rd_en[i]),
      .zero  (clear_busy),
      .word  (mem[rd_addr[i*AW +: AW]]),
      .data  (rd_data[i*DATA_W +: DATA_W]),
      .valid (rd_valid[i])
    );
  end
endmodule

// File: tb/tb_instruction_mem_mp.sv
// Bench for instruction_mem_mp: directed scenarios plus random bursts and reads,
// checked against a flag/array model of the store and its sequencing.

module tb_instruction_mem_mp;
  localparam int DW = 16, D = 32, NS = 4, AW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear_req = 1'b0, load_start = 1'b0, load_valid = 1'b0;
  logic [AW-1:0]     load_base = '0;
  logic [AW:0]       load_len = '0;
  logic [DW-1:0]     load_data = '0;
  logic              clear_busy, load_ready, load_done;
  logic [NS-1:0]     rd_en = '0;
  logic [NS*AW-1:0]  rd_addr = '0;
  logic [NS*DW-1:0]  rd_data;
  logic [NS-1:0]     rd_valid;

  instruction_mem_mp #(.DATA_W(DW), .DEPTH(D), .NUM_SM(NS)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(clear_busy),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;

  // Reference model
  logic [DW-1:0] mm [D];
  logic [DW-1:0] last_rd [NS];
  bit clearing, loading;
  int cp, lp, lc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    clearing = 1; cp = 0; loading = 0; lp = 0; lc = 0;
    for (int i = 0; i < NS; i++) last_rd[i] = '0;
  endtask

  // One clock: drive inputs, predict, advance, compare.
  task automatic step(input logic lv, input logic [DW-1:0] d, input logic [NS-1:0] en,
                      input logic [NS*AW-1:0] ad, input logic clr = 0, input logic ls = 0,
                      input logic [AW-1:0] base = 0, input logic [AW:0] len = 0);
    logic [DW-1:0] exp_rd [NS];
    bit dn;
    load_valid = lv; load_data = d; rd_en = en; rd_addr = ad;
    clear_req = clr; load_start = ls; load_base = base; load_len = len;
    for (int i = 0; i < NS; i++) begin
      exp_rd[i] = en[i] ? (clearing ? '0 : mm[ad[i*AW +: AW]]) : last_rd[i];
      last_rd[i] = exp_rd[i];
    end
    dn = 0;
    if (clearing) begin
      mm[cp] = '0;
      if (cp == D-1) clearing = 0; else cp++;
    end else if (loading) begin
      if (lv) begin
        mm[lp] = d; lp = (lp + 1) % D; lc--;
        if (lc == 0) begin loading = 0; dn = 1; end
      end
    end else if (clr) begin
      clearing = 1; cp = 0;
    end else if (ls) begin
      if (len == 0) dn = 1;
      else begin loading = 1; lp = int'(base); lc = int'(len); end
    end
    @(posedge clk); #1;
    load_valid = 0; load_start = 0; clear_req = 0; rd_en = '0;
    chk("clear_busy", 64'(clear_busy), 64'(clearing));
    chk("load_ready", 64'(load_ready), 64'(loading));
    chk("load_done", 64'(load_done), 64'(dn));
    chk("rd_valid", 64'(rd_valid), 64'(en));
    for (int i = 0; i < NS; i++)
      chk($sformatf("rd_data[%0d]", i), 64'(rd_data[i*DW +: DW]), 64'(exp_rd[i]));
  endtask

  task automatic idle_rand();
    step(0, DW'($urandom), NS'($urandom), (NS*AW)'($urandom));
  endtask

  task automatic wait_clear();
    int n = 0;
    while (clear_busy === 1'b1 && n < 100) begin idle_rand(); n++; end
    chk("clear_cycles", 64'(n), 64'(D));
  endtask

  task automatic read_all();
    for (int g = 0; g < D/NS; g++) begin
      logic [NS*AW-1:0] ad;
      for (int i = 0; i < NS; i++) ad[i*AW +: AW] = AW'(g*NS + i);
      step(0, '0, '1, ad);
    end
  endtask

  task automatic read_same(input logic [AW-1:0] a);
    step(0, '0, '1, {NS{a}});
  endtask

  initial begin
    for (int i = 0; i < D; i++) mm[i] = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clear_busy", 64'(clear_busy), 64'd1);
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    rst = 1;
    wait_clear();
    read_all();

    // Basic load with a 2-cycle gap after beat 1
    step(0, '0, '0, '0, 0, 1, 5'd4, 6'd3);
    step(1, 16'hA001, '0, '0);
    step(0, 16'hFFFF, '0, '0);
    step(0, 16'hFFFF, '0, '0);
    step(1, 16'hA002, '0, '0);
    step(1, 16'hA003, '0, '0);
    step(0, '0, '0, '0);
    read_same(5'd4); read_same(5'd5); read_same(5'd6); read_same(5'd7);

    // Wrap-around
    step(0, '0, '0, '0, 0, 1, 5'd30, 6'd4);
    step(1, 16'h1111, '0, '0);
    step(1, 16'h2222, '0, '0);
    step(1, 16'h3333, '0, '0);
    step(1, 16'h4444, '0, '0);
    read_same(5'd30); read_same(5'd31); read_same(5'd0); read_same(5'd1); read_same(5'd2);

    // Collision: all ports read addr 5 while it is written
    step(0, '0, '0, '0, 0, 1, 5'd5, 6'd1);
    step(1, 16'hBEEF, '1, {NS{5'd5}});
    read_same(5'd5);
    chk("collision_new", 64'(rd_data[DW-1:0]), 64'h BEEF);

    // Clear and load together: clear wins
    step(0, '0, '0, '0, 1, 1, 5'd10, 6'd3);
    wait_clear();
    read_all();

    // Zero-length load: immediate done, no write
    step(1, 16'hDEAD, '0, '0, 0, 1, 5'd7, 6'd0);
    step(0, '0, '0, '0);
    read_same(5'd7);

    // Random bursts with stalls, ignored starts and concurrent reads
    for (int b = 0; b < 6; b++) begin
      int guard = 0;
      step(0, '0, '0, '0, 0, 1, AW'($urandom_range(0, D-1)), (AW+1)'($urandom_range(1, D)));
      while (loading && guard < 300) begin
        step(($urandom_range(0, 3) != 0), DW'($urandom), NS'($urandom), (NS*AW)'($urandom),
             1'($urandom), 1'($urandom), AW'($urandom), (AW+1)'($urandom));
        guard++;
      end
      chk("burst_finished", 64'(loading), 64'd0);
      repeat (8) idle_rand();
    end
    read_all();

    // Reset mid-load
    step(0, '0, '0, '0, 0, 1, 5'd20, 6'd5);
    step(1, 16'h5001, '0, '0);
    step(1, 16'h5002, '0, '0);
    rst = 0;
    #1;
    model_reset();
    chk("mid_rst_clear_busy", 64'(clear_busy), 64'd1);
    chk("mid_rst_load_ready", 64'(load_ready), 64'd0);
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_rd_data", 64'(rd_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_load_done", 64'(load_done), 64'd0);
    rst = 1;
    wait_clear();
    read_all();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
